// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions.
// Provides the datapath word width, the result/status bundle type and the
// occupancy encoding used by the 2-entry skid buffer. All ALU execution units
// share these definitions.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  typedef logic [ALU_WIDTH-1:0] word_t;

  typedef struct packed {
    word_t res;
    logic  zero;
    logic  neg;
  } alu_result_t;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,  // nothing held
    SKID_MAIN  = 2'd1,  // main register valid, skid register empty
    SKID_FULL  = 2'd2   // main and skid registers both valid
  } skid_state_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready skid buffer: a main (output) register plus a skid
// register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake; in_ready is !skid_full
//   in_data  [W]         payload accepted on an input transfer
//   out_valid/out_ready  downstream handshake
//   out_data [W]         payload in the main register (zero after reset)
module alu_skid_buffer
  import alu_pkg::*;
#(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t state, state_next;
  logic [W-1:0] main_q, skid_q;
  logic         in_xfer, out_xfer;
  logic         load_main_in, load_main_skid, load_skid;

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (state != SKID_FULL);
  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = main_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          state_next   = SKID_MAIN;
        end
      end
      SKID_MAIN: begin
        if (in_xfer && out_xfer) begin
          // Pass-through: main is replaced, skid stays unused.
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          load_skid  = 1'b1;
          state_next = SKID_FULL;
        end else if (out_xfer) begin
          state_next = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (out_xfer) begin
          load_main_skid = 1'b1;
          state_next     = SKID_MAIN;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SKID_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/bitwise_or.sv
// Registered bitwise-OR execution unit with zero/negative status flags.
// The OR result and its flags are formed combinationally and registered
// together through a 2-entry skid buffer (1-cycle latency, full throughput).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake
//   A, B [WIDTH]         operands
//   out_valid/out_ready  result handshake
//   out [WIDTH]          A | B
//   zero                 out == 0
//   neg                  out[WIDTH-1]
module bitwise_or
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg
);

  logic [WIDTH-1:0] res;
  logic             res_zero, res_neg;
  logic [WIDTH+1:0] payload_in, payload_out;

  assign res        = A | B;
  assign res_zero   = (res == '0);
  assign res_neg    = res[WIDTH-1];
  assign payload_in = {res, res_zero, res_neg};

  alu_skid_buffer #(
    .W(WIDTH + 2)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (payload_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (payload_out)
  );

  assign {out, zero, neg} = payload_out;

endmodule

// File: tb/tb_bitwise_or.sv
// Self-checking bench for bitwise_or: directed cases followed by random
// valid/ready traffic, compared against a queue-based model of the unit.
module tb_bitwise_or;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zero;
  logic        neg;

  int checks = 0;
  int errors = 0;

  // Results in flight, oldest first; capacity 2.
  int unsigned model_q[$];

  bitwise_or #(
    .WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .zero     (zero),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned r;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      r = model_q[0];
      check({tag, ".out"}, 64'(out), 64'(r));
      check({tag, ".zero"}, 64'(zero), 64'(r == 0));
      check({tag, ".neg"}, 64'(neg), 64'(r >= 32768));
    end
  endtask

  // Called just after a falling edge: drive, take one rising edge, update
  // the model, then check on the following falling edge.
  task automatic cycle(input string tag, input logic iv, input logic [15:0] a,
                       input logic [15:0] b, input logic ordy);
    bit ix, ox;
    in_valid  = iv;
    A         = a;
    B         = b;
    out_ready = ordy;
    @(posedge clk);
    ix = iv && (model_q.size() < 2);
    ox = (model_q.size() > 0) && ordy;
    if (ox) void'(model_q.pop_front());
    if (ix) model_q.push_back(int'(a) | int'(b));
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out", 64'(out), 64'd0);
    check("rst.zero", 64'(zero), 64'd0);
    check("rst.neg", 64'(neg), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs("post_rst");

    // Single operations.
    cycle("zero_op", 1'b1, 16'h0000, 16'h0000, 1'b1);
    cycle("or_a",    1'b1, 16'h0666, 16'h3080, 1'b1);
    cycle("neg_op",  1'b1, 16'h8666, 16'h0000, 1'b1);
    cycle("drain0",  1'b0, 16'h0000, 16'h0000, 1'b1);

    // Back-to-back stream.
    cycle("b2b0", 1'b1, 16'h0666, 16'h3080, 1'b1);
    cycle("b2b1", 1'b1, 16'h8666, 16'h0000, 1'b1);
    cycle("b2b2", 1'b1, 16'hFFFF, 16'h0001, 1'b1);
    cycle("b2b3", 1'b0, 16'h0000, 16'h0000, 1'b1);

    // Stall with streaming input, then release.
    cycle("stall0", 1'b1, 16'h1234, 16'h4001, 1'b0);
    cycle("stall1", 1'b1, 16'hA000, 16'h0005, 1'b0);
    cycle("stall2", 1'b1, 16'h0F0F, 16'hF0F0, 1'b0);
    cycle("rel0",   1'b0, 16'h0000, 16'h0000, 1'b1);
    cycle("rel1",   1'b0, 16'h0000, 16'h0000, 1'b1);
    cycle("rel2",   1'b0, 16'h0000, 16'h0000, 1'b1);

    // Fill both entries, then reset asynchronously mid-stall.
    cycle("fill0", 1'b1, 16'h8001, 16'h0010, 1'b0);
    cycle("fill1", 1'b1, 16'h0300, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.out", 64'(out), 64'd0);
    check("arst.zero", 64'(zero), 64'd0);
    check("arst.neg", 64'(neg), 64'd0);
    model_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs("arst_rel");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      cycle("rand", ($urandom_range(0, 3) != 0), ra, rb, ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) begin
      cycle("final_drain", 1'b0, 16'h0000, 16'h0000, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
